// File: rtl/stuffed_frame_tx_if.sv
// Word-in / bit-out bundle for the stuffed serial frame transmitter.
// Producer side drives tx_data/tx_valid; the transmitter drives everything else.
`timescale 1ns/1ps
interface stuffed_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sout;
  logic              sout_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sout, sout_en, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sout, sout_en, busy, frame_done
  );
endinterface

// File: rtl/stuffed_frame_tx.sv
// Serial frame transmitter: PRE_LEN ones, 0 delimiter, MSB-first zero-stuffed payload, 0 guard.
// Latency: first preamble bit the cycle after handshake; ready only in IDLE, word held by producer otherwise.
`timescale 1ns/1ps
module stuffed_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2,
  parameter int MAX_RUN = 1
) (
  input logic              clk,
  input logic              rst,
  stuffed_frame_tx_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int PRE_W = $clog2(PRE_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DELIM = 3'd2,
    S_DATA  = 3'd3,
    S_STUFF = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [RUN_W-1:0]  r_run;
  logic [PRE_W-1:0]  r_pre;
  logic              r_last;

  logic w_ready, w_sout, w_sout_en, w_busy, w_done;
  logic w_hs, w_bit, w_stuff, w_pre_last, w_idx_zero;

  assign w_hs       = bus.tx_valid & w_ready;
  assign w_bit      = r_shift[r_idx];
  assign w_stuff    = w_bit && (r_run == RUN_W'(MAX_RUN - 1));
  assign w_pre_last = (r_pre == PRE_W'(PRE_LEN - 1));
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_hs ? S_PRE : S_IDLE;
      S_PRE:   w_next = w_pre_last ? S_DELIM : S_PRE;
      S_DELIM: w_next = S_DATA;
      S_DATA: begin
        if (w_stuff)         w_next = S_STUFF;
        else if (w_idx_zero) w_next = S_END;
        else                 w_next = S_DATA;
      end
      S_STUFF: w_next = r_last ? S_END : S_DATA;
      S_END:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters saturate at their terminal value so none wraps inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_run   <= '0;
      r_pre   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_shift <= bus.tx_data;
            r_idx   <= '0;
            r_run   <= '0;
            r_pre   <= '0;
            r_last  <= 1'b0;
          end
        end
        S_PRE: begin
          if (!w_pre_last) r_pre <= r_pre + PRE_W'(1);
        end
        S_DELIM: begin
          r_idx <= IDX_W'(DATA_W - 1);
          r_run <= '0;
        end
        S_DATA: begin
          r_run <= w_bit ? r_run + RUN_W'(1) : '0;
          if (w_idx_zero) r_last <= 1'b1;
          else            r_idx  <= r_idx - IDX_W'(1);
        end
        S_STUFF: r_run <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ready   = 1'b0;
    w_sout    = 1'b0;
    w_sout_en = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = ~rst;
      S_PRE: begin
        w_sout    = 1'b1;
        w_sout_en = 1'b1;
        w_busy    = 1'b1;
      end
      S_DELIM, S_STUFF: begin
        w_sout_en = 1'b1;
        w_busy    = 1'b1;
      end
      S_DATA: begin
        w_sout    = w_bit;
        w_sout_en = 1'b1;
        w_busy    = 1'b1;
      end
      S_END: begin
        w_sout_en = 1'b1;
        w_busy    = 1'b1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.tx_ready   = w_ready;
  assign bus.sout       = w_sout;
  assign bus.sout_en    = w_sout_en;
  assign bus.busy       = w_busy;
  assign bus.frame_done = w_done;

endmodule

// File: tb/tb_stuffed_frame_tx.sv
// Bench for stuffed_frame_tx: default instance plus a PRE_LEN=3/MAX_RUN=2 instance, checked against a frame model.
`timescale 1ns/1ps
module tb_stuffed_frame_tx;
  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stuffed_frame_tx_if #(.DATA_W(8)) if0 ();
  stuffed_frame_tx_if #(.DATA_W(8)) if2 ();

  stuffed_frame_tx #(.DATA_W(8), .PRE_LEN(2), .MAX_RUN(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  stuffed_frame_tx #(.DATA_W(8), .PRE_LEN(3), .MAX_RUN(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  wire m_en   = (sel == 1) ? if2.sout_en    : if0.sout_en;
  wire m_sout = (sel == 1) ? if2.sout       : if0.sout;
  wire m_done = (sel == 1) ? if2.frame_done : if0.frame_done;
  wire m_rdy  = (sel == 1) ? if2.tx_ready   : if0.tx_ready;

  bitq_t cap_sout;
  bit    cap_done_ok;
  bit    cap_to;

  // Frame built directly from the layout rules: preamble, delimiter, payload with a 0 after every
  // MAX_RUN consecutive ones, guard.
  function automatic bitq_t model_frame(input logic [7:0] d, input int pre_len, input int max_run);
    bitq_t q;
    int    ones = 0;
    for (int i = 0; i < pre_len; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) begin
      q.push_back(d[i]);
      ones = d[i] ? ones + 1 : 0;
      if (ones == max_run) begin
        q.push_back(1'b0);
        ones = 0;
      end
    end
    q.push_back(1'b0);
    return q;
  endfunction

  function automatic bit same(input bitq_t a, input bitq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pack(input bitq_t q, input int lo, input int n);
    logic [31:0] v = '0;
    for (int i = lo; i < lo + n && i < q.size(); i++) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic send(input logic [7:0] d, input bit keep);
    bit r;
    bit ok = 1'b0;
    if (sel == 1) begin if2.tx_data = d; if2.tx_valid = 1'b1; end
    else          begin if0.tx_data = d; if0.tx_valid = 1'b1; end
    for (int c = 0; c < 50; c++) begin
      r = m_rdy;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    if (!keep) begin if0.tx_valid = 1'b0; if2.tx_valid = 1'b0; end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL handshake_timeout sel=%0d data=%02h", sel, d); end
  endtask

  task automatic capture(input int budget);
    int ndone = 0;
    bit last_done = 1'b0;
    cap_sout.delete();
    cap_to = 1'b0;
    for (int c = 0; ; c++) begin
      if (c >= budget) begin cap_to = 1'b1; break; end
      if (!m_en) break;
      cap_sout.push_back(m_sout);
      ndone += int'(m_done);
      last_done = m_done;
      @(posedge clk); #1;
    end
    cap_done_ok = (ndone == 1) && last_done;
    n_tests++;
    if (cap_to) begin n_fail++; $display("FAIL capture_timeout sel=%0d got=%0d cycles", sel, budget); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    #12;
    n_tests++;
    if ({if0.tx_ready, if0.sout, if0.sout_en, if0.busy, if0.frame_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs0 got=%b want=00000",
        {if0.tx_ready, if0.sout, if0.sout_en, if0.busy, if0.frame_done});
    end
    n_tests++;
    if ({if2.tx_ready, if2.sout_en, if2.busy} !== 3'b0) begin
      n_fail++; $display("FAIL reset_outputs2 got=%b want=000", {if2.tx_ready, if2.sout_en, if2.busy});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({if0.tx_ready, if0.busy, if0.sout_en} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after_reset got=%b want=100", {if0.tx_ready, if0.busy, if0.sout_en});
    end
  endtask

  task automatic test_zero();
    sel = 0;
    n_tests++;
    if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL ready_before_hs got=%b want=1", m_rdy); end
    send(8'h00, 1'b0);
    capture(40);
    n_tests++;
    if (cap_sout.size() != 12 || pack(cap_sout, 0, 12) !== 32'hC00) begin
      n_fail++; $display("FAIL zero_frame got=%0d bits %h want=12 bits c00", cap_sout.size(), pack(cap_sout, 0, 12));
    end
    n_tests++;
    if (!cap_done_ok) begin n_fail++; $display("FAIL zero_done got=misplaced want=last_cycle_only"); end
    n_tests++;
    if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after got=%b want=1", m_rdy); end
  endtask

  task automatic test_a5();
    bit pair = 1'b0;
    sel = 0;
    send(8'hA5, 1'b0);
    capture(40);
    n_tests++;
    if (cap_sout.size() != 16 || pack(cap_sout, 0, 16) !== 32'hD224) begin
      n_fail++; $display("FAIL a5_frame got=%0d bits %h want=16 bits d224", cap_sout.size(), pack(cap_sout, 0, 16));
    end
    for (int i = 4; i < cap_sout.size(); i++) if (cap_sout[i] && cap_sout[i-1]) pair = 1'b1;
    n_tests++;
    if (pair) begin n_fail++; $display("FAIL a5_no_11 got=11_in_payload want=none"); end
  endtask

  task automatic test_ff();
    sel = 0;
    send(8'hFF, 1'b0);
    capture(40);
    n_tests++;
    if (cap_sout.size() != 20 || !same(cap_sout, model_frame(8'hFF, 2, 1))) begin
      n_fail++; $display("FAIL ff_run1 got=%0d bits %h want=20 bits %h", cap_sout.size(),
        pack(cap_sout, 0, 20), pack(model_frame(8'hFF, 2, 1), 0, 20));
    end
    sel = 1;
    send(8'hFF, 1'b0);
    capture(40);
    n_tests++;
    if (cap_sout.size() != 17 || pack(cap_sout, 4, 12) !== 32'hDB6 || pack(cap_sout, 0, 4) !== 32'hE) begin
      n_fail++; $display("FAIL ff_run2 got=%0d bits %h want=17 bits e db6 0", cap_sout.size(), pack(cap_sout, 0, 17));
    end
    n_tests++;
    if (!cap_done_ok) begin n_fail++; $display("FAIL ff_run2_done got=misplaced want=last_cycle_only"); end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    bitq_t f1, f2, exp_en, exp_s, got_en, got_s;
    bit seen_done = 1'b0;
    bit drop;
    sel = 0;
    f1 = model_frame(8'h3C, 2, 1);
    f2 = model_frame(8'hC3, 2, 1);
    foreach (f1[i]) begin exp_en.push_back(1'b1); exp_s.push_back(f1[i]); end
    exp_en.push_back(1'b0); exp_s.push_back(1'b0);
    foreach (f2[i]) begin exp_en.push_back(1'b1); exp_s.push_back(f2[i]); end
    exp_en.push_back(1'b0); exp_s.push_back(1'b0);
    send(8'h3C, 1'b1);
    for (int c = 0; c < exp_en.size(); c++) begin
      got_en.push_back(if0.sout_en);
      got_s.push_back(if0.sout);
      if (if0.frame_done && !seen_done) begin seen_done = 1'b1; if0.tx_data = 8'hC3; end
      else if (!seen_done) if0.tx_data = 8'($urandom);
      drop = if0.tx_ready && seen_done;
      @(posedge clk); #1;
      if (drop) if0.tx_valid = 1'b0;
    end
    if0.tx_valid = 1'b0;
    n_tests++;
    if (!same(got_en, exp_en)) begin
      n_fail++; $display("FAIL b2b_gap got_en=%h want_en=%h", pack(got_en, 0, 32), pack(exp_en, 0, 32));
    end
    n_tests++;
    if (!same(got_s, exp_s)) begin
      n_fail++; $display("FAIL b2b_data got=%h want=%h", pack(got_s, 0, 32), pack(exp_s, 0, 32));
    end
    capture(10);
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    logic [7:0] d;
    sel = 0;
    send(8'hA5, 1'b0);
    for (int c = 0; c < 9; c++) begin @(posedge clk); #1; end
    n_tests++;
    if (if0.sout_en !== 1'b1) begin n_fail++; $display("FAIL mid_frame_active got=%b want=1", if0.sout_en); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({if0.sout, if0.sout_en, if0.busy, if0.frame_done} !== 4'b0) begin
      n_fail++; $display("FAIL async_reset got=%b want=0000", {if0.sout, if0.sout_en, if0.busy, if0.frame_done});
    end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; saw_done |= if0.frame_done; end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; saw_done |= if0.frame_done; end
    n_tests++;
    if (saw_done) begin n_fail++; $display("FAIL abandoned_done got=1 want=0"); end
    d = 8'($urandom);
    send(d, 1'b0);
    capture(40);
    n_tests++;
    if (!same(cap_sout, model_frame(d, 2, 1)) || !cap_done_ok) begin
      n_fail++; $display("FAIL post_reset_frame data=%02h got=%h want=%h", d,
        pack(cap_sout, 0, 24), pack(model_frame(d, 2, 1), 0, 24));
    end
  endtask

  task automatic test_random_loopback();
    logic [7:0] d;
    int pre, mr, run;
    bit bad, hit;
    for (int n = 0; n < 16; n++) begin
      sel = n % 2;
      pre = (sel == 1) ? 3 : 2;
      mr  = (sel == 1) ? 2 : 1;
      d = 8'($urandom);
      send(d, 1'b0);
      capture(40);
      n_tests++;
      if (!same(cap_sout, model_frame(d, pre, mr)) || !cap_done_ok) begin
        n_fail++; $display("FAIL rand_frame sel=%0d data=%02h got=%h want=%h", sel, d,
          pack(cap_sout, 0, 24), pack(model_frame(d, pre, mr), 0, 24));
      end
      run = 0; bad = 1'b0; hit = 1'b0;
      for (int i = 0; i < cap_sout.size(); i++) begin
        run = cap_sout[i] ? run + 1 : 0;
        if (run > mr) begin
          if (i < pre) hit = 1'b1;
          else         bad = 1'b1;
        end
      end
      n_tests++;
      if (bad || !hit) begin
        n_fail++; $display("FAIL detector sel=%0d data=%02h payload_hit=%b preamble_hit=%b want=0/1", sel, d, bad, hit);
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_a5();
    test_ff();
    test_back_to_back();
    test_reset_mid();
    test_random_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
